// File: rtl/wb_cmd_master.sv
// Wishbone classic single-transfer master: turns a valid/ready command stream into one
// bus cycle per command and returns data/status on a valid/ready response stream.
module wb_cmd_master #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic [3:0]  cmd_sel_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_dat_o,
  output logic        rsp_err_o,
  output logic        rsp_tmo_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic [31:0] wbm_dat_i
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam logic          TMO_EN   = (TIMEOUT != 0);
  localparam logic [TW-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

  state_t        state;
  logic [TW-1:0] wait_cnt;
  logic          bus_cyc;

  // cyc and stb are one register: single transfers never insert stb-low gaps
  assign wbm_cyc_o = bus_cyc;
  assign wbm_stb_o = bus_cyc;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      bus_cyc     <= 1'b0;
      cmd_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_dat_o   <= '0;
      rsp_err_o   <= 1'b0;
      rsp_tmo_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      wbm_sel_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            wbm_we_o    <= cmd_we_i;
            wbm_adr_o   <= cmd_adr_i;
            wbm_dat_o   <= cmd_dat_i;
            wbm_sel_o   <= cmd_sel_i;
            bus_cyc     <= 1'b1;
            cmd_ready_o <= 1'b0;
            wait_cnt    <= '0;
            state       <= BUS;
          end else begin
            cmd_ready_o <= 1'b1;
          end
        end
        BUS: begin
          // err beats ack; either beats the timeout on the same edge
          if (wbm_err_i) begin
            bus_cyc     <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
            rsp_tmo_o   <= 1'b0;
            rsp_dat_o   <= '0;
            state       <= RESP;
          end else if (wbm_ack_i) begin
            bus_cyc     <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b0;
            rsp_tmo_o   <= 1'b0;
            rsp_dat_o   <= wbm_we_o ? 32'd0 : wbm_dat_i;
            state       <= RESP;
          end else if (TMO_EN && (wait_cnt == TMO_LAST)) begin
            bus_cyc     <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
            rsp_tmo_o   <= 1'b1;
            rsp_dat_o   <= '0;
            state       <= RESP;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_tmo_o   <= 1'b0;
            rsp_dat_o   <= '0;
            cmd_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Scoreboard bench for wb_cmd_master: stimulus pushes expected bus cycles and responses,
// independent monitors pop and compare them as the DUT presents them.
module tb_wb_cmd_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_tmo;
  logic [31:0] rsp_dat;
  logic        cyc, stb, we;
  logic [31:0] adr, wdat, rdat;
  logic [3:0]  sel;
  logic        ack, err, slv_ack, slv_err, stray_ack;

  assign ack = slv_ack | stray_ack;
  assign err = slv_err;

  always #5 clk = ~clk;

  wb_cmd_master #(.TIMEOUT(4), .TW(8)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_err_o(rsp_err), .rsp_tmo_o(rsp_tmo),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_adr_o(adr),
    .wbm_dat_o(wdat), .wbm_sel_o(sel),
    .wbm_ack_i(ack), .wbm_err_i(err), .wbm_dat_i(rdat)
  );

  typedef struct { logic [31:0] dat; logic err; logic tmo; } rsp_t;
  typedef struct { logic we; logic [31:0] adr; logic [31:0] dat; logic [3:0] sel; int len; } bus_t;

  rsp_t rsp_q[$];
  bus_t bus_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rsp_cnt = 0;
  int   rsp_exp = 0;

  // slave behaviour: 0 ack, 1 err, 2 ack+err, 3 never respond
  int          slv_mode = 0;
  int          slv_wait = 0;
  logic [31:0] slv_rdat = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // slave model: drives ack/err after slv_wait stb cycles, sampled by the DUT at the next rising edge
  initial begin
    int wcnt;
    wcnt = 0;
    slv_ack = 1'b0;
    slv_err = 1'b0;
    rdat = '0;
    forever begin
      @(negedge clk);
      if (cyc && stb) begin
        if (slv_mode != 3 && wcnt == slv_wait) begin
          slv_ack = (slv_mode == 0 || slv_mode == 2);
          slv_err = (slv_mode == 1 || slv_mode == 2);
          rdat    = slv_rdat;
        end else begin
          slv_ack = 1'b0;
          slv_err = 1'b0;
          rdat    = 32'h0BAD_0BAD;
        end
        wcnt++;
      end else begin
        slv_ack = 1'b0;
        slv_err = 1'b0;
        wcnt = 0;
      end
    end
  end

  // bus monitor: checks fields at cycle start and cycle length at cycle end (len 0 = not checked)
  initial begin
    int   run;
    logic prev;
    bus_t e;
    run = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (cyc && !prev) begin
        if (bus_q.size() == 0) fail_now("bus_unexpected_cycle");
        else begin
          e = bus_q[0];
          chk("bus_stb", 32'(stb), 32'd1);
          chk("bus_we", 32'(we), 32'(e.we));
          chk("bus_adr", adr, e.adr);
          chk("bus_dat", wdat, e.dat);
          chk("bus_sel", 32'(sel), 32'(e.sel));
        end
      end
      if (cyc) run++;
      if (!cyc && prev) begin
        if (bus_q.size() != 0) begin
          e = bus_q.pop_front();
          if (e.len != 0) chk("cyc_len", 32'(run), 32'(e.len));
        end
        run = 0;
      end
      prev = cyc;
    end
  end

  // response monitor: pops one expectation per valid&ready handshake
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) fail_now("rsp_unexpected");
        else begin
          e = rsp_q.pop_front();
          chk("rsp_dat", rsp_dat, e.dat);
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("rsp_tmo", 32'(rsp_tmo), 32'(e.tmo));
        end
        rsp_cnt++;
      end
    end
  end

  task automatic expect_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int len, input bit has_rsp,
                            input logic [31:0] rd, input logic re, input logic rt);
    bus_t b;
    rsp_t r;
    b.we = w; b.adr = a; b.dat = d; b.sel = s; b.len = len;
    bus_q.push_back(b);
    if (has_rsp) begin
      r.dat = rd; r.err = re; r.tmo = rt;
      rsp_q.push_back(r);
      rsp_exp++;
    end
  endtask

  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit accepted;
    int k;
    accepted = 1'b0;
    k = 0;
    @(posedge clk); #1;
    cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = s; cmd_valid = 1'b1;
    while (!accepted && k < 50) begin
      @(negedge clk);
      if (cmd_ready) accepted = 1'b1;
      @(posedge clk); #1;
      k++;
    end
    cmd_valid = 1'b0;
    cmd_we = ~w; cmd_adr = 32'hFFFF_FFFF; cmd_dat = 32'h5555_AAAA; cmd_sel = 4'h0;
    if (!accepted) fail_now("cmd_accept_timeout");
  endtask

  task automatic wait_rsp();
    int k;
    k = 0;
    while (rsp_cnt < rsp_exp && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (rsp_cnt < rsp_exp) fail_now("rsp_wait_timeout");
  endtask

  task automatic slave(input int mode, input int wt, input logic [31:0] d);
    slv_mode = mode; slv_wait = wt; slv_rdat = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b1; stray_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_cyc", 32'(cyc), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_bits", {rsp_dat[29:0], rsp_err, rsp_tmo}, 32'd0);
    chk("rst_bus_fields", adr | wdat | {27'd0, we, sel}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_release", 32'(cmd_ready), 32'd1);

    // zero-wait write
    slave(0, 0, 32'h0);
    expect_cmd(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 1, 1'b1, 32'h0, 1'b0, 1'b0);
    send(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
    wait_rsp();

    // read with 3 waits: ack lands on the timeout edge and must win
    slave(0, 3, 32'h1234_5678);
    expect_cmd(1'b0, 32'h3000_0000, 32'hDEAD_BEEF, 4'hF, 4, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
    send(1'b0, 32'h3000_0000, 32'hDEAD_BEEF, 4'hF);
    wait_rsp();

    // write with 2 waits, partial lanes; read data on bus must not leak into response
    slave(0, 2, 32'h9999_9999);
    expect_cmd(1'b1, 32'h3000_0010, 32'h0000_00A5, 4'h3, 3, 1'b1, 32'h0, 1'b0, 1'b0);
    send(1'b1, 32'h3000_0010, 32'h0000_00A5, 4'h3);
    wait_rsp();

    // slave never responds: timeout after 4 stb cycles
    slave(3, 0, 32'h0);
    expect_cmd(1'b0, 32'h3000_0020, 32'h0000_00A5, 4'hF, 4, 1'b1, 32'h0, 1'b1, 1'b1);
    send(1'b0, 32'h3000_0020, 32'h0000_00A5, 4'hF);
    wait_rsp();

    // ack and err together: error wins, data forced to 0
    slave(2, 1, 32'h7777_7777);
    expect_cmd(1'b0, 32'h3000_0030, 32'h0000_00A5, 4'hF, 2, 1'b1, 32'h0, 1'b1, 1'b0);
    send(1'b0, 32'h3000_0030, 32'h0000_00A5, 4'hF);
    wait_rsp();

    // plain bus error on a zero-wait read
    slave(1, 0, 32'h6666_6666);
    expect_cmd(1'b0, 32'h3000_0034, 32'h0000_00A5, 4'h1, 1, 1'b1, 32'h0, 1'b1, 1'b0);
    send(1'b0, 32'h3000_0034, 32'h0000_00A5, 4'h1);
    wait_rsp();

    // stray ack while idle is ignored
    @(posedge clk); #1;
    stray_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    stray_ack = 1'b0;
    chk("stray_cyc", 32'(cyc), 32'd0);
    chk("stray_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("stray_cmd_ready", 32'(cmd_ready), 32'd1);

    // response backpressure with a second command waiting
    rsp_ready = 1'b0;
    slave(0, 0, 32'hCAFE_F00D);
    expect_cmd(1'b0, 32'h3000_0038, 32'h0000_00A5, 4'hF, 1, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0);
    send(1'b0, 32'h3000_0038, 32'h0000_00A5, 4'hF);
    begin
      int k;
      k = 0;
      while (!rsp_valid && k < 20) begin @(posedge clk); #1; k++; end
      if (!rsp_valid) fail_now("bp_rsp_never_valid");
    end
    expect_cmd(1'b1, 32'h0000_0040, 32'h0000_0040, 4'h1, 1, 1'b1, 32'h0, 1'b0, 1'b0);
    cmd_we = 1'b1; cmd_adr = 32'h0000_0040; cmd_dat = 32'h0000_0040; cmd_sel = 4'h1; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_dat", rsp_dat, 32'hCAFE_F00D);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_hs_ready", 32'(cmd_ready), 32'd1);
    chk("post_hs_no_cyc", 32'(cyc), 32'd0);
    @(posedge clk); #1;
    chk("post_hs_accept_cyc", 32'(cyc), 32'd1);
    cmd_valid = 1'b0;
    wait_rsp();

    // reset during a stalled bus cycle
    slave(3, 0, 32'h0);
    expect_cmd(1'b0, 32'h3000_0050, 32'h0000_0040, 4'hF, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    send(1'b0, 32'h3000_0050, 32'h0000_0040, 4'hF);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_cyc", 32'(cyc), 32'd0);
    chk("midrst_stb", 32'(stb), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ready_release", 32'(cmd_ready), 32'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);

    // traffic resumes normally
    slave(0, 0, 32'h1111_2222);
    expect_cmd(1'b0, 32'h3000_0060, 32'h0000_0040, 4'hF, 1, 1'b1, 32'h1111_2222, 1'b0, 1'b0);
    send(1'b0, 32'h3000_0060, 32'h0000_0040, 4'hF);
    wait_rsp();

    repeat (3) @(posedge clk);
    chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    chk("bus_q_drained", 32'(bus_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
